// File: rtl/drawframe_pkg.sv
// drawframe_pkg: shared constants and types for the DrawFrame AXI4-Lite
// register file.
//   REG_*           register indices (address bits [3:2])
//   NUM_REGS        number of 32-bit configuration registers
//   AXI_RESP_OKAY   the only response this block ever returns
//   w_state_t       write channel states
//   r_state_t       read channel states
//   addr_to_idx()   byte address -> register index
package drawframe_pkg;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;

  localparam int REG_CTRL         = 0;
  localparam int REG_TOP_LEFT     = 1;
  localparam int REG_BOTTOM_RIGHT = 2;
  localparam int REG_COLOR        = 3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // Word select only: byte offset bits [1:0] are ignored and anything above
  // bit 3 aliases onto the same four registers.
  function automatic reg_idx_t addr_to_idx(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/drawframe_axil_if.sv
// drawframe_axil_if: AXI4-Lite bus bundle for the DrawFrame S00_AXI port.
//   AW: awaddr, awprot, awvalid, awready
//   W : wdata, wstrb, wvalid, wready
//   B : bresp, bvalid, bready
//   AR: araddr, arprot, arvalid, arready
//   R : rdata, rresp, rvalid, rready
// Modports: master (PS / VIP side), slave (register file side).
interface drawframe_axil_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );

endinterface

// File: rtl/drawframe_strb_merge.sv
// drawframe_strb_merge: combinational byte-lane merge for a strobed write.
//   old_data  current register contents
//   new_data  write data from the bus
//   strb      byte enables; lane i takes new_data when strb[i]=1
//   merged    resulting register value
module drawframe_strb_merge
  import drawframe_pkg::*;
(
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] new_data,
  input  logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    // NOTE: assign a default before the conditional lane updates so every
    // bit is written on every path; otherwise synthesis infers latches.
    merged = old_data;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/drawframe_axil_slave.sv
// drawframe_axil_slave: AXI4-Lite register file for the DrawFrame IP.
// Holds CTRL, TOP_LEFT, BOTTOM_RIGHT and COLOR, drives them to the overlay
// datapath and pulses a per-register strobe on each committed write.
//   ACLK       clock, rising edge
//   ARESET     asynchronous active-high reset
//   s00_axi    AXI4-Lite slave port (drawframe_axil_if.slave)
//   reg_o      register contents, reg0 in bits [31:0]
//   reg_upd_o  one-cycle pulse per register on a committed write
module drawframe_axil_slave
  import drawframe_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  drawframe_axil_if.slave            s00_axi,
  output logic [NUM_REGS*DATA_W-1:0] reg_o,
  output logic [NUM_REGS-1:0]        reg_upd_o
);

  if (C_S_AXI_DATA_WIDTH != DATA_W) begin : g_bad_data_width
    $error("drawframe_axil_slave supports only a 32-bit data bus");
  end
  if (C_S_AXI_ADDR_WIDTH < 4) begin : g_bad_addr_width
    $error("drawframe_axil_slave needs at least 4 address bits");
  end

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             reg_upd;

  // Write channel state
  w_state_t           w_state;
  logic               aw_done;
  logic               w_done;
  reg_idx_t           aw_idx;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;
  logic               bvalid;
  logic [DATA_W-1:0]  merged;

  // Read channel state
  r_state_t           r_state;
  logic               rvalid;
  logic [DATA_W-1:0]  rdata;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  // PROT and the aliased/byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot,
                       s00_axi.awaddr, s00_axi.araddr};

  // READY is decoded from registered state rather than registered itself so
  // the first handshake can land on the first edge after reset release;
  // gating with ARESET keeps it low while reset is held.
  assign s00_axi.awready = !ARESET && (w_state == W_IDLE) && !aw_done;
  assign s00_axi.wready  = !ARESET && (w_state == W_IDLE) && !w_done;
  assign s00_axi.arready = !ARESET && (r_state == R_IDLE);

  assign aw_hs = s00_axi.awvalid && s00_axi.awready;
  assign w_hs  = s00_axi.wvalid  && s00_axi.wready;
  assign ar_hs = s00_axi.arvalid && s00_axi.arready;

  assign s00_axi.bvalid = bvalid;
  assign s00_axi.bresp  = AXI_RESP_OKAY;
  assign s00_axi.rvalid = rvalid;
  assign s00_axi.rdata  = rdata;
  assign s00_axi.rresp  = AXI_RESP_OKAY;

  assign reg_o     = regs;
  assign reg_upd_o = reg_upd;

  drawframe_strb_merge u_strb_merge (
    .old_data (regs[aw_idx]),
    .new_data (wdata_q),
    .strb     (wstrb_q),
    .merged   (merged)
  );

  // Write channel: AW and W are latched independently in W_IDLE; once both
  // are held the register commits on the following edge together with
  // BVALID and the update strobe.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bvalid  <= 1'b0;
      reg_upd <= '0;
      // NOTE: these are configuration flops, not a RAM, so they take the
      // reset like any other state; an SRAM-backed file could not.
      regs    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so a read sampling regs
      // on the commit edge still sees the pre-write value.
      reg_upd <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_done && w_done) begin
            regs[aw_idx]    <= merged;
            reg_upd[aw_idx] <= 1'b1;
            bvalid          <= 1'b1;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            w_state         <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_done <= 1'b1;
              aw_idx  <= addr_to_idx(s00_axi.awaddr[3:0]);
            end
            if (w_hs) begin
              w_done  <= 1'b1;
              wdata_q <= s00_axi.wdata;
              wstrb_q <= s00_axi.wstrb;
            end
          end
        end
        W_RESP: begin
          if (s00_axi.bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: data is captured on the AR handshake and held until the
  // master takes it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata   <= regs[addr_to_idx(s00_axi.araddr[3:0])];
            rvalid  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (s00_axi.rready) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drawframe_axil_slave.sv
// tb_drawframe_axil_slave: directed and randomized checks of the DrawFrame
// AXI4-Lite register file against a word/byte array model.
module tb_drawframe_axil_slave;

  logic aclk = 1'b0;
  logic areset;
  logic [127:0] reg_o;
  logic [3:0]   reg_upd_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [4];

  always #5 aclk = ~aclk;

  drawframe_axil_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) s_axi ();

  drawframe_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4)
  ) dut (
    .ACLK      (aclk),
    .ARESET    (areset),
    .s00_axi   (s_axi),
    .reg_o     (reg_o),
    .reg_upd_o (reg_upd_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One write: AW and W raised after their own delays (cycles), BREADY held
  // low for b_dly cycles after BVALID appears.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly,
                           input int w_dly, input int b_dly);
    bit aw_got = 0;
    bit w_got  = 0;
    bit aw_hs, w_hs;
    int t = 0;
    int n = 0;
    int idx = int'(addr[3:2]);
    s_axi.bready = 1'b0;
    while (!(aw_got && w_got) && t < 50) begin
      if (t == aw_dly) begin s_axi.awaddr = addr; s_axi.awvalid = 1'b1; end
      if (t == w_dly) begin
        s_axi.wdata = data; s_axi.wstrb = strb; s_axi.wvalid = 1'b1;
      end
      aw_hs = s_axi.awvalid && s_axi.awready;
      w_hs  = s_axi.wvalid && s_axi.wready;
      tick();
      if (aw_hs) begin s_axi.awvalid = 1'b0; aw_got = 1; end
      if (w_hs)  begin s_axi.wvalid  = 1'b0; w_got  = 1; end
      if (w_got && !aw_got) check("wready_low_after_w", 128'(s_axi.wready), 128'(0));
      if (aw_got && !w_got) check("awready_low_after_aw", 128'(s_axi.awready), 128'(0));
      t++;
    end
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    check("aw_w_accepted", 128'({aw_got, w_got}), 128'(2'b11));
    for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    while (!s_axi.bvalid && n < 10) begin tick(); n++; end
    check("b_latency", 128'(n), 128'(1));
    check("bresp", 128'(s_axi.bresp), 128'(0));
    check("reg_upd_pulse", 128'(reg_upd_o), 128'(4'b0001 << idx));
    check("reg_o_after_write", reg_o, model_flat());
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_held", 128'(s_axi.bvalid), 128'(1));
      check("ready_low_in_resp", 128'({s_axi.awready, s_axi.wready}), 128'(0));
      check("reg_upd_single", 128'(reg_upd_o), 128'(0));
    end
    s_axi.bready = 1'b1;
    tick();
    s_axi.bready = 1'b0;
    check("bvalid_cleared", 128'(s_axi.bvalid), 128'(0));
    check("reg_upd_cleared", 128'(reg_upd_o), 128'(0));
  endtask

  // One read, RREADY held low for r_dly cycles after RVALID.
  task automatic axi_read(input logic [3:0] addr, input int r_dly);
    logic [31:0] exp_data = model[addr[3:2]];
    bit got = 0;
    bit hs;
    int t = 0;
    s_axi.araddr  = addr;
    s_axi.arvalid = 1'b1;
    s_axi.rready  = 1'b0;
    while (!got && t < 50) begin
      hs = s_axi.arvalid && s_axi.arready;
      tick();
      if (hs) got = 1;
      t++;
    end
    s_axi.arvalid = 1'b0;
    check("ar_accepted", 128'(got), 128'(1));
    check("rvalid_latency", 128'(s_axi.rvalid), 128'(1));
    check("rdata", 128'(s_axi.rdata), 128'(exp_data));
    check("rresp", 128'(s_axi.rresp), 128'(0));
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("rdata_stable", 128'({s_axi.rvalid, s_axi.rdata}), 128'({1'b1, exp_data}));
      check("arready_low_in_data", 128'(s_axi.arready), 128'(0));
    end
    s_axi.rready = 1'b1;
    tick();
    s_axi.rready = 1'b0;
    check("rvalid_cleared", 128'(s_axi.rvalid), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    logic [31:0] old_color;
    areset = 1'b1;
    s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata  = '0; s_axi.wstrb  = '0; s_axi.wvalid  = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state
    repeat (2) tick();
    check("rst_ready", 128'({s_axi.awready, s_axi.wready, s_axi.arready}), 128'(0));
    check("rst_valid", 128'({s_axi.bvalid, s_axi.rvalid}), 128'(0));
    check("rst_regs", reg_o, 128'(0));
    check("rst_upd", 128'(reg_upd_o), 128'(0));
    check("rst_rdata_resp", 128'({s_axi.rdata, s_axi.rresp, s_axi.bresp}), 128'(0));
    areset = 1'b0;
    #1;
    check("ready_after_release", 128'({s_axi.awready, s_axi.wready, s_axi.arready}), 128'(3'b111));

    // Sequential writes with readback
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
      axi_read(4'(4 * i), 1);
    end
    check("seq_reg_o", reg_o, {32'h4, 32'h3, 32'h2, 32'h1});

    // W three cycles ahead of AW
    axi_write(4'h4, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    check("top_left", 128'(reg_o[63:32]), 128'(32'hDEADBEEF));

    // Byte strobes
    axi_write(4'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(4'hA, 32'h00000000, 4'b0101, 1, 1, 0);
    axi_read(4'h8, 0);
    check("strb_bottom_right", 128'(reg_o[95:64]), 128'(32'hFF00FF00));

    // WSTRB=0: response and pulse, contents unchanged
    axi_write(4'h0, 32'hA5A5A5A5, 4'h0, 0, 0, 0);

    // Back-pressure on B
    axi_write(4'h5, 32'h12345678, 4'hF, 0, 0, 5);

    // Read of COLOR sampled on the same edge a write to COLOR commits
    old_color = model[3];
    s_axi.awaddr = 4'hC; s_axi.wdata = 32'h55; s_axi.wstrb = 4'hF;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b1;
    check("ovl_aw_w_ready", 128'({s_axi.awready, s_axi.wready}), 128'(2'b11));
    tick();
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.araddr = 4'hC; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
    check("ovl_arready", 128'(s_axi.arready), 128'(1));
    tick();
    s_axi.arvalid = 1'b0;
    model[3] = 32'h55;
    check("ovl_old_rdata", 128'({s_axi.rvalid, s_axi.rdata}), 128'({1'b1, old_color}));
    check("ovl_commit", 128'({s_axi.bvalid, reg_upd_o}), 128'({1'b1, 4'b1000}));
    check("ovl_reg_o", reg_o, model_flat());
    tick();
    s_axi.bready = 1'b0;
    check("ovl_b_done", 128'(s_axi.bvalid), 128'(0));
    for (int i = 0; i < 3; i++) begin
      check("ovl_rdata_hold", 128'({s_axi.rvalid, s_axi.rdata}), 128'({1'b1, 32'h4}));
      tick();
    end
    s_axi.rready = 1'b1;
    tick();
    s_axi.rready = 1'b0;
    check("ovl_rvalid_cleared", 128'(s_axi.rvalid), 128'(0));
    axi_read(4'hC, 0);

    // Reset while RVALID is pending
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
    s_axi.araddr = 4'h0; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
    tick();
    s_axi.arvalid = 1'b0;
    check("pre_rst_rdata", 128'({s_axi.rvalid, s_axi.rdata}), 128'({1'b1, 32'h1}));
    areset = 1'b1;
    #1;
    check("async_rst_rvalid", 128'(s_axi.rvalid), 128'(0));
    check("async_rst_regs", reg_o, 128'(0));
    check("async_rst_ready", 128'({s_axi.awready, s_axi.wready, s_axi.arready}), 128'(0));
    for (int i = 0; i < 4; i++) model[i] = '0;
    tick();
    tick();
    areset = 1'b0;
    #1;
    axi_read(4'h0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
      else
        axi_read(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end
    check("final_reg_o", reg_o, model_flat());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
